// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } sup_state_e;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_STABLE_CYCLES  = 60000;
  localparam int DEF_HOLD_CYCLES    = 600;
  localparam int DEF_LOSS_CNT_W     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 6000000;

  // A window of one cycle still needs a one-bit counter to compare against zero.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_ff_chain.sv
// Multi-flop synchronizer for a single asynchronous level; resets to 0.
module sync_ff_chain
  import pll_sup_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Turns the raw PLL lock flag into a qualified system reset and lock status.
// Optional lock watchdog enabled by defining PLL_LOCK_WATCHDOG_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int LOSS_CNT_W     = DEF_LOSS_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  locked,
  input  logic                  clear_sticky,
  output logic                  sys_reset,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic [2:0]            state_o,
  output logic                  lock_timeout
);

  localparam int SW = cnt_width(STABLE_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic                  locked_s;
  sup_state_e            state_q, state_d;
  logic [SW-1:0]         stab_cnt_q, stab_cnt_d;
  logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
  logic                  sys_reset_q, sys_reset_d;
  logic                  ready_q, ready_d;
  logic                  lock_lost_q, lock_lost_d;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic                  loss_evt;

  sync_ff_chain #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (locked),
    .q_o   (locked_s)
  );

  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    hold_cnt_d = hold_cnt_q;
    loss_evt   = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        stab_cnt_d = '0;
        if (locked_s) state_d = STABILIZE;
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d    = WAIT_LOCK;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d    = RUN;
          stab_cnt_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          loss_evt   = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = WAIT_LOCK;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Outputs are registered from the next state so they change on the transition edge.
    sys_reset_d = (state_d != RUN);
    ready_d     = (state_d == RUN);
    lock_lost_d = loss_evt | (lock_lost_q & ~clear_sticky);
    loss_cnt_d  = loss_cnt_q;
    if (loss_evt && (loss_cnt_q != '1)) loss_cnt_d = loss_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_LOCK;
      stab_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      stab_cnt_q  <= stab_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  assign sys_reset  = sys_reset_q;
  assign ready      = ready_q;
  assign lock_lost  = lock_lost_q;
  assign loss_count = loss_cnt_q;
  assign state_o    = {1'b0, state_q};

`ifdef PLL_LOCK_WATCHDOG_EN
  localparam int WW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic          timeout_q, timeout_d;

  // The counter parks at its limit so it cannot wrap while the flag stays sticky.
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if (state_q == RUN || state_q == HOLD) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q == WD_LAST) begin
      timeout_d = 1'b1;
    end else begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign lock_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign lock_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed table, corner sequences,
// and randomized lock traffic compared against a streak/timer reference model.
module tb_pll_lock_supervisor;

  localparam int SYNC  = 2;
  localparam int STAB  = 8;
  localparam int HOLDC = 4;
  localparam int LW    = 8;
  localparam int TO    = 32;
`ifdef PLL_LOCK_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          locked;
  logic          clear_sticky;
  logic          sys_reset;
  logic          ready;
  logic          lock_lost;
  logic [LW-1:0] loss_count;
  logic [2:0]    state_o;
  logic          lock_timeout;

  always #5 clock = ~clock;

  pll_lock_supervisor #(
    .SYNC_STAGES    (SYNC),
    .STABLE_CYCLES  (STAB),
    .HOLD_CYCLES    (HOLDC),
    .LOSS_CNT_W     (LW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .locked       (locked),
    .clear_sticky (clear_sticky),
    .sys_reset    (sys_reset),
    .ready        (ready),
    .lock_lost    (lock_lost),
    .loss_count   (loss_count),
    .state_o      (state_o),
    .lock_timeout (lock_timeout)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a delay line for the synchronizer, then a run of
  // consecutive lock cycles that must reach STAB+1 (one to leave WAIT_LOCK plus
  // the window), and a countdown of hold cycles after each loss.
  bit mPipe[SYNC];
  bit mRun;
  int mStreak;
  int mHoldLeft;
  int mWdEdges;
  bit mLost;
  bit mTimeout;
  int mLossCount;

  function automatic void modelReset();
    for (int i = 0; i < SYNC; i++) mPipe[i] = 1'b0;
    mRun = 0; mStreak = 0; mHoldLeft = 0; mWdEdges = 0;
    mLost = 0; mTimeout = 0; mLossCount = 0;
  endfunction

  function automatic void modelEdge(input bit lk, input bit cs);
    bit ls, lossNow, waiting;
    ls = mPipe[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) mPipe[i] = mPipe[i-1];
    mPipe[0] = lk;
    waiting = !mRun && (mHoldLeft == 0);
    lossNow = 1'b0;
    if (mRun) begin
      if (!ls) begin
        mRun = 0; mHoldLeft = HOLDC; lossNow = 1'b1;
      end
    end else if (mHoldLeft > 0) begin
      mHoldLeft--;
    end else begin
      mStreak = ls ? mStreak + 1 : 0;
      if (mStreak == STAB + 1) begin
        mRun = 1; mStreak = 0;
      end
    end
    if (lossNow) begin
      mLost = 1'b1;
      if (mLossCount < (2**LW) - 1) mLossCount++;
    end else if (cs) begin
      mLost = 1'b0;
    end
    if (WD_EN) begin
      mWdEdges = waiting ? mWdEdges + 1 : 0;
      if (mWdEdges >= TO) mTimeout = 1'b1;
    end
  endfunction

  function automatic int modelState();
    if (mRun) return 2;
    if (mHoldLeft > 0) return 3;
    if (mStreak > 0) return 1;
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_sys_reset"}, 32'(sys_reset), 32'(!mRun));
    checkOutput({tag, "_ready"}, 32'(ready), 32'(mRun));
    checkOutput({tag, "_state"}, 32'(state_o), 32'(modelState()));
    checkOutput({tag, "_lock_lost"}, 32'(lock_lost), 32'(mLost));
    checkOutput({tag, "_loss_count"}, 32'(loss_count), 32'(mLossCount));
    checkOutput({tag, "_timeout"}, 32'(lock_timeout), 32'(mTimeout));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input bit lk, input bit cs);
    locked       = lk;
    clear_sticky = cs;
    @(posedge clock);
    modelEdge(lk, cs);
    @(negedge clock);
  endtask

  task automatic doReset();
    reset        = 1'b1;
    locked       = 1'b0;
    clear_sticky = 1'b0;
    modelReset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    bit         lk;
    bit         cs;
    int         n;
    bit         expRst;
    bit         expRdy;
    logic [2:0] expState;
    bit         expLost;
    int         expCount;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int  edges;
    bit  lk, cs;

    // Glitch in STABILIZE, full requalification, loss in RUN, sticky clear, clear-vs-set.
    tbl[0]  = '{1'b1, 1'b0, 8, 1'b1, 1'b0, 3'd1, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1, 1'b1, 1'b0, 3'd1, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 3'd1, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 3'd0, 1'b0, 0};
    tbl[4]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 3'd1, 1'b0, 0};
    tbl[5]  = '{1'b1, 1'b0, 7, 1'b1, 1'b0, 3'd1, 1'b0, 0};
    tbl[6]  = '{1'b1, 1'b0, 1, 1'b0, 1'b1, 3'd2, 1'b0, 0};
    tbl[7]  = '{1'b0, 1'b0, 2, 1'b0, 1'b1, 3'd2, 1'b0, 0};
    tbl[8]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 3'd3, 1'b1, 1};
    tbl[9]  = '{1'b1, 1'b0, 3, 1'b1, 1'b0, 3'd3, 1'b1, 1};
    tbl[10] = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 3'd0, 1'b1, 1};
    tbl[11] = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 3'd1, 1'b1, 1};
    tbl[12] = '{1'b1, 1'b0, 7, 1'b1, 1'b0, 3'd1, 1'b1, 1};
    tbl[13] = '{1'b1, 1'b0, 1, 1'b0, 1'b1, 3'd2, 1'b1, 1};
    tbl[14] = '{1'b1, 1'b1, 1, 1'b0, 1'b1, 3'd2, 1'b0, 1};
    tbl[15] = '{1'b0, 1'b0, 2, 1'b0, 1'b1, 3'd2, 1'b0, 1};
    tbl[16] = '{1'b1, 1'b1, 1, 1'b1, 1'b0, 3'd3, 1'b1, 2};

    reset = 1'b1; locked = 1'b0; clear_sticky = 1'b0;
    @(negedge clock);
    doReset();
    checkOutput("reset_sys_reset", 32'(sys_reset), 32'd1);
    checkOutput("reset_ready", 32'(ready), 32'd0);
    checkOutput("reset_state", 32'(state_o), 32'd0);
    checkOutput("reset_lock_lost", 32'(lock_lost), 32'd0);
    checkOutput("reset_loss_count", 32'(loss_count), 32'd0);
    checkOutput("reset_timeout", 32'(lock_timeout), 32'd0);

    for (int i = 0; i < 17; i++) begin
      repeat (tbl[i].n) applyStimulus(tbl[i].lk, tbl[i].cs);
      checkOutput($sformatf("tbl%0d_sys_reset", i), 32'(sys_reset), 32'(tbl[i].expRst));
      checkOutput($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].expRdy));
      checkOutput($sformatf("tbl%0d_state", i), 32'(state_o), 32'(tbl[i].expState));
      checkOutput($sformatf("tbl%0d_lock_lost", i), 32'(lock_lost), 32'(tbl[i].expLost));
      checkOutput($sformatf("tbl%0d_loss_count", i), 32'(loss_count), 32'(tbl[i].expCount));
      checkOutput($sformatf("tbl%0d_timeout", i), 32'(lock_timeout), 32'd0);
    end

    // Release latency with lock present from the first cycle.
    doReset();
    edges = 0;
    while (edges < 20) begin
      applyStimulus(1'b1, 1'b0);
      edges++;
      if (!sys_reset) break;
    end
    checkOutput("release_edge", 32'(edges), 32'd11);
    checkOutput("release_ready", 32'(ready), 32'd1);
    checkOutput("release_state", 32'(state_o), 32'd2);

    // Asynchronous reset taken while in HOLD.
    repeat (2) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkAll("pre_reset_hold");
    #2 reset = 1'b1;
    modelReset();
    #1;
    checkOutput("midreset_sys_reset", 32'(sys_reset), 32'd1);
    checkOutput("midreset_ready", 32'(ready), 32'd0);
    checkOutput("midreset_state", 32'(state_o), 32'd0);
    checkOutput("midreset_lock_lost", 32'(lock_lost), 32'd0);
    checkOutput("midreset_loss_count", 32'(loss_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Saturation: 300 losses on an 8-bit counter.
    doReset();
    for (int i = 0; i < 301; i++) begin
      repeat (2) applyStimulus(1'b0, 1'b0);
      repeat (16) applyStimulus(1'b1, 1'b0);
    end
    checkOutput("sat_loss_count", 32'(loss_count), 32'd255);
    checkAll("sat");

    // Watchdog with lock never arriving.
    doReset();
    repeat (TO - 1) applyStimulus(1'b0, 1'b0);
    checkOutput("wd_before_limit", 32'(lock_timeout), 32'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("wd_at_limit", 32'(lock_timeout), 32'(WD_EN));
    checkOutput("wd_sys_reset", 32'(sys_reset), 32'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("wd_sticky_vs_clear", 32'(lock_timeout), 32'(WD_EN));
    checkAll("wd");

    // Randomized lock traffic against the reference model.
    doReset();
    lk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, lk ? 40 : 12) == 0) lk = ~lk;
      cs = ($urandom_range(0, 9) == 0);
      applyStimulus(lk, cs);
      checkAll("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
